// File: rtl/div_strobe_pkg.sv
// div_strobe_pkg: shared FSM state type and sample counter width for div_strobe_sampler.
package div_strobe_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int CNT_W = 16;
endpackage

// File: rtl/div_strobe_fifo.sv
// div_strobe_fifo: small FIFO whose head output is registered and holds its last value when empty.
module div_strobe_fifo #(
  parameter int DATA_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr, rd_nxt;
  logic [AW:0] count, left;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign left    = count - (AW+1)'(do_pop);
  assign rd_nxt  = rd + AW'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  // the push bypasses storage when it lands in an otherwise empty FIFO
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      rd    <= rd_nxt;
      wr    <= wr + AW'(do_push);
      count <= left + (AW+1)'(do_push);
      if (left != '0) head <= mem[rd_nxt];
      else if (do_push) head <= din;
    end
endmodule

// File: rtl/div_strobe_sampler.sv
// div_strobe_sampler: clock-enable divider producing sub_clk and sampling data_in on each rise into a FIFO.
// Define DIV_STROBE_LATE_SAMPLE_EN to defer each capture by one clk (post-update data).
module div_strobe_sampler
  import div_strobe_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int DIV_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  half_period,
  input  logic [DATA_W-1:0] data_in,
  output logic              sub_clk,
  output logic              sub_rise,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [CNT_W-1:0]  sample_cnt
);
  state_t state;
  logic [DIV_W-1:0] cnt, per;
  logic [DATA_W-1:0] cap_d;
  logic tc, rise, cap_v, full, empty, pop, accept;
  assign tc        = cnt == per;
  assign rise      = state == RUN && tc && !sub_clk;
  assign out_valid = !empty;
  assign pop       = out_ready && out_valid;
  assign accept    = cap_v && (!full || pop);
  // STOP only runs the divider while sub_clk is high, so it can never produce a rise
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      per      <= '0;
      sub_clk  <= 1'b0;
      sub_rise <= 1'b0;
    end else begin
      sub_rise <= rise;
      if (state == IDLE) begin
        cnt     <= '0;
        sub_clk <= 1'b0;
        if (en) begin
          state <= RUN;
          per   <= half_period;
        end
      end else if (state == RUN || sub_clk) begin
        cnt <= tc ? '0 : cnt + 1'b1;
        if (tc) sub_clk <= !sub_clk;
        if (state == RUN && !en) state <= STOP;
        else if (state == STOP && tc) state <= IDLE;
      end else begin
        cnt   <= '0;
        state <= IDLE;
      end
    end
`ifdef DIV_STROBE_LATE_SAMPLE_EN
  logic pend;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend  <= 1'b0;
      cap_v <= 1'b0;
      cap_d <= '0;
    end else begin
      pend  <= rise;
      cap_v <= pend;
      if (pend) cap_d <= data_in;
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap_v <= 1'b0;
      cap_d <= '0;
    end else begin
      cap_v <= rise;
      if (rise) cap_d <= data_in;
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (cap_v && !accept) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (accept) sample_cnt <= sample_cnt + 1'b1;
    end
  div_strobe_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cap_v),
    .pop  (pop),
    .din  (cap_d),
    .full (full),
    .empty(empty),
    .head (out_data)
  );
endmodule

// File: tb/tb_div_strobe_sampler.sv
// tb_div_strobe_sampler: scoreboard bench for div_strobe_sampler (DATA_W=8, DEPTH=4).
module tb_div_strobe_sampler;
  import div_strobe_pkg::*;
`ifdef DIV_STROBE_LATE_SAMPLE_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
  logic [3:0] half_period = '0;
  logic [7:0] data_in = '0;
  logic sub_clk, sub_rise, out_valid, overflow;
  logic [7:0] out_data;
  logic [15:0] sample_cnt;
  logic [7:0] q [$];
  int tests = 0, fails = 0, n;

  div_strobe_sampler #(.DATA_W(8), .DIV_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .half_period(half_period), .data_in(data_in),
    .sub_clk(sub_clk), .sub_rise(sub_rise), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow), .clr_ovf(clr_ovf), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // compare the head just before the edge that pops it, then advance one clk
  task automatic step();
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_pop", 1, 0);
      else check("pop_data", out_data, q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_sub_clk", sub_clk, 0);
    check("rst_sub_rise", sub_rise, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", sample_cnt, 0);

    // half_period=0, incrementing data: every other value is captured
    for (int i = 0; i < 4; i++) q.push_back(8'(2 * i + L));
    half_period = 0; out_ready = 1'b1; data_in = 8'hee; en = 1'b1;
    step();
    for (int k = 0; k < 7; k++) begin data_in = 8'(k); step(); end
    en = 1'b0;
    for (int k = 7; k < 13; k++) begin data_in = 8'(k); step(); end
    check("t1_drain", q.size(), 0);
    check("t1_idle", dut.state, IDLE);
    check("t1_cnt", sample_cnt, 4);

    // half_period=2, mid-run period change ignored, stop while high
    do_reset();
    repeat (3) q.push_back(8'ha5);
    half_period = 2; en = 1'b1; data_in = 8'ha5; out_ready = 1'b1;
    step();
    half_period = 0;
    step(); step();
    check("t2_pre", sub_clk, 0);
    step();
    check("t2_rise_clk", sub_clk, 1);
    check("t2_rise_pulse", sub_rise, 1);
    step();
    check("t2_pulse_one", sub_rise, 0);
    n = 0;
    repeat (11) begin step(); n += int'(sub_rise); end
    check("t2_rises", n, 2);
    check("t2_hi", sub_clk, 1);
    en = 1'b0; step();
    en = 1'b1; step();
    check("t2_stop_hold", sub_clk, 1);
    check("t2_stop_state", dut.state, STOP);
    en = 1'b0; step();
    check("t2_fall", sub_clk, 0);
    check("t2_idle", dut.state, IDLE);
    n = 0;
    repeat (6) begin step(); n += int'(sub_rise); end
    check("t2_no_rise", n, 0);
    check("t2_drain", q.size(), 0);

    // 5 captures into a 4-deep FIFO with no consumer
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'(10 + i));
    half_period = 0; en = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      data_in = 8'(10 + k);
      step();
      if (k == 4) en = 1'b0;
      step();
    end
    repeat (3) step();
    check("t3_valid", out_valid, 1);
    check("t3_cnt", sample_cnt, 4);
    check("t3_ovf", overflow, 1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    check("t3_clr", overflow, 0);
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    check("t3_drain", q.size(), 0);
    check("t3_empty", out_valid, 0);

    // full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < 5; i++) q.push_back(8'(10 + i));
    half_period = 0; en = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin data_in = 8'(10 + k); step(); step(); end
    data_in = 8'd14;
    step();
    en = 1'b0;
    if (L == 0) out_ready = 1'b1;
    step();
    out_ready = (L == 1);
    step();
    out_ready = 1'b0;
    check("t4_ovf", overflow, 0);
    check("t4_cnt", sample_cnt, 5);
    check("t4_full", dut.u_fifo.full, 1);
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    check("t4_drain", q.size(), 0);

    // async reset mid-run with two entries queued, then restart
    do_reset();
    half_period = 2; data_in = 8'd3; en = 1'b1;
    step();
    repeat (11) step();
    check("t6_cnt_pre", sample_cnt, 2);
    check("t6_clk_pre", sub_clk, 1);
    rst = 1'b1;
    #2;
    check("t6_valid", out_valid, 0);
    check("t6_cnt", sample_cnt, 0);
    check("t6_clk", sub_clk, 0);
    check("t6_data", out_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; half_period = 0; en = 1'b1;
    step();
    step();
    check("t6_new_rise", sub_clk, 1);
    check("t6_new_pulse", sub_rise, 1);
    step();
    check("t6_new_fall", sub_clk, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/div_strobe_sampler.md
# div_strobe_sampler

Clock-enable divider plus capture stage that produces the derived slow clock for downstream slow-domain logic and samples an upstream fast-domain data bus on each derived rising edge, with a fixed, race-free ordering between the derived edge and the data update. Captured samples are buffered in a small FIFO with a valid/ready output. The stage sits between the fast-clock counter logic and the slow-clock consumer, replacing directly clocked derived-clock flops.

## Interface
- DATA_W, default 2: width of sampled bus.
- DIV_W, default 4: width of half-period setting.
- DEPTH, default 4: FIFO entries; power of two, >= 2.
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request.
- half_period  in  DIV_W  sub_clk toggles every half_period+1 clk cycles; latched on IDLE->RUN.
- data_in  in  DATA_W  fast-domain data to sample.
- sub_clk  out  1  derived clock, registered.
- sub_rise  out  1  one-cycle pulse, high in the cycle sub_clk first reads 1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  DATA_W  FIFO head entry.
- overflow  out  1  sticky; a capture was dropped.
- clr_ovf  in  1  synchronous clear of overflow.
- sample_cnt  out  16  captures accepted into FIFO, wraps at 2^16.

## Operation
- Reset values: sub_clk 0, sub_rise 0, out_valid 0, out_data 0, overflow 0, sample_cnt 0, FSM IDLE, divider count 0, FIFO empty, latched period 0.
- FSM states: IDLE, RUN, STOP.
- IDLE: sub_clk held 0, divider held 0. en=1 -> RUN, latch half_period.
- RUN: divider counts 0..latched period; at terminal count sub_clk toggles and count returns to 0. en=0 -> STOP.
- STOP: divider keeps running. If sub_clk=0, go to IDLE immediately. Otherwise go to IDLE on the toggle that drives sub_clk to 0. en reasserted in STOP is ignored until IDLE is reached.
- Capture: the clk edge that drives sub_clk 0->1 captures data_in as sampled at that same edge (pre-update value, NBA semantics).
- FIFO: a capture pushes to the tail; out_ready && out_valid pops the head.
  - Push when full with no pop in the same cycle: sample dropped, overflow set, sample_cnt unchanged.
  - Push and pop in the same cycle when full: both take effect, no overflow.
  - Push into an empty FIFO: out_valid rises the next cycle.
- out_data holds its last value when the FIFO is empty. It is registered from the head entry.
- clr_ovf and a new overflow in the same cycle: overflow stays 1.
- half_period changes during RUN or STOP take no effect.

## Timing
- Divide ratio 2*(half_period+1). half_period=0 gives sub_clk toggling every clk.
- Latency from en rising (sampled at edge N) to first sub_clk rise: edge N+1+half_period.
- sub_rise is asserted for exactly one cycle per sub_clk rising edge.
- Capture to out_valid: 1 cycle when the FIFO is empty.
- rst asserted mid-operation: all outputs take their reset values immediately; FIFO contents are discarded.

## Configuration
- DIV_STROBE_LATE_SAMPLE_EN
  - Undefined (default): capture uses data_in at the sub_clk rising edge.
  - Defined: capture is deferred by one clk and uses data_in one cycle later (post-update value). The FIFO push and sample_cnt increment move one cycle later.
  - Defined, with rst during the deferred cycle: the pending capture is discarded.
  - Defined, with the STOP->IDLE transition during the deferred cycle: the pending capture still completes.

## Structure
- Shared package div_strobe_pkg holds the FSM state enum (IDLE, RUN, STOP) and the sample_cnt width constant, 16.
- One sub-module, div_strobe_fifo: parameterised by DATA_W and DEPTH; provides push, pop, full, empty, head.
- The divider, FSM, capture and overflow logic live in the top-level module.

## Test plan
- half_period=0, bench data_in incrementing each clk from 0 at the edge of the first rise, out_ready=1:
  - Default build: out_data sequence 0,2,4,6.
  - With DIV_STROBE_LATE_SAMPLE_EN defined: sequence 1,3,5,7.
- half_period=2, en held high: sub_clk period is 6 clk; sub_rise asserts once per 6 cycles; first rise at edge N+3 after en sampled at N.
- out_ready=0, 5 captures, DEPTH=4: out_valid=1, sample_cnt=4, overflow=1. A clr_ovf pulse then clears overflow. Popping yields the first 4 samples in order.
- FIFO full, push and pop in the same cycle: overflow stays 0, sample_cnt increments, FIFO stays full.
- en dropped while sub_clk=1 in RUN: no further sub_rise; sub_clk falls at the next terminal count; state reaches IDLE. en reasserted during STOP has no effect until IDLE.
- rst pulsed mid-RUN with 2 entries queued: out_valid=0, sample_cnt=0, sub_clk=0 immediately. Restart latches the new half_period.
